id_operand_stage: RTL

- Decode/operand-fetch stage of the RV32I pipeline. Sits directly downstream of the IF/ID register and directly upstream of EX.
- Drives the register file read addresses and forwards EX/MEM results over stale register file data.
- Generates immediates and detects load-use hazards.
- Registers everything into the ID/EX pipeline register, with stall and flush.

---
 rtl/id_operand_stage_pkg.sv | 33 +++
 rtl/id_operand_stage_imm_gen.sv | 27 ++
 rtl/id_operand_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/id_operand_stage_pkg.sv
// Shared RV32I decode constants and opcode-class helpers for the ID operand stage.
package id_operand_stage_pkg;

    typedef logic [31:0] reg_bus_t;
    typedef logic [4:0]  reg_addr_bus_t;

    localparam reg_bus_t      ZERO_WORD = '0;
    localparam reg_addr_bus_t ZERO_REG  = '0;
    localparam reg_bus_t      NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    function automatic logic uses_rs1(input logic [6:0] opc);
        return opc inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR};
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return opc inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    endfunction

    function automatic logic writes_rd(input logic [6:0] opc);
        return opc inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
    endfunction

endpackage

// File: rtl/id_operand_stage_imm_gen.sv
// Combinational RV32I immediate generator: sign-extended I/S/B/U/J immediates by opcode.
module id_operand_stage_imm_gen
    import id_operand_stage_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = ZERO_WORD;
        case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/id_operand_stage.sv
// RV32I decode/operand-fetch stage: register read, EX/MEM forwarding, load-use
// stall detection, immediate generation and the ID/EX pipeline register.
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter logic [31:0] NOP_INSTR  = id_operand_stage_pkg::NOP_INSTR
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_instr,
    input  logic [XLEN-1:0]       id_pc,
    output logic [REG_ADDR_W-1:0] rf_raddr1,
    output logic [REG_ADDR_W-1:0] rf_raddr2,
    input  logic [XLEN-1:0]       rf_rdata1,
    input  logic [XLEN-1:0]       rf_rdata2,
    input  logic                  exmem_regwrite,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic                  ex_regwrite_fb,
    input  logic [XLEN-1:0]       ex_result_fb,
    input  logic                  flush,
    output logic                  stall_req,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_instr,
    output logic [XLEN-1:0]       ex_rs1_data,
    output logic [XLEN-1:0]       ex_rs2_data,
    output logic [XLEN-1:0]       ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_regwrite,
    output logic                  ex_memread
);

    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  use_rs1;
    logic                  use_rs2;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       fwd_rs1;
    logic [XLEN-1:0]       fwd_rs2;
    logic                  ex_fwd_ok;
    logic                  bubble;

    assign opcode    = id_instr[6:0];
    assign rs1       = id_instr[19:15];
    assign rs2       = id_instr[24:20];
    assign rd        = id_instr[11:7];
    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;
    assign use_rs1   = uses_rs1(opcode);
    assign use_rs2   = uses_rs2(opcode);

    id_operand_stage_imm_gen u_imm_gen (
        .instr (id_instr),
        .imm   (imm)
    );

    // A load in EX has no result yet; that case is covered by the stall instead.
    assign ex_fwd_ok = ex_regwrite_fb && !ex_memread && ex_valid;

    always_comb begin
        fwd_rs1 = '0;
        if (rs1 != '0) begin
            if (ex_fwd_ok && ex_rd == rs1)
                fwd_rs1 = ex_result_fb;
            else if (exmem_regwrite && exmem_rd == rs1)
                fwd_rs1 = exmem_result;
            else
                fwd_rs1 = rf_rdata1;
        end
    end

    always_comb begin
        fwd_rs2 = '0;
        if (rs2 != '0) begin
            if (ex_fwd_ok && ex_rd == rs2)
                fwd_rs2 = ex_result_fb;
            else if (exmem_regwrite && exmem_rd == rs2)
                fwd_rs2 = exmem_result;
            else
                fwd_rs2 = rf_rdata2;
        end
    end

    assign stall_req = !rst_n && id_valid && ex_valid && ex_memread && (ex_rd != '0) &&
                       ((use_rs1 && ex_rd == rs1) || (use_rs2 && ex_rd == rs2));

    assign bubble = flush || stall_req || !id_valid;

    // Reset is active-high despite the legacy port name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_instr    <= NOP_INSTR;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
        end else if (bubble) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_instr    <= NOP_INSTR;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
        end else begin
            ex_valid    <= 1'b1;
            ex_pc       <= id_pc;
            ex_instr    <= id_instr;
            ex_rs1_data <= fwd_rs1;
            ex_rs2_data <= fwd_rs2;
            ex_imm      <= imm;
            ex_rd       <= rd;
            ex_regwrite <= writes_rd(opcode) && (rd != '0);
            ex_memread  <= (opcode == OPC_LOAD);
        end
    end

endmodule
